// File: rtl/ac2_pkg.sv
// Shared types and helpers for the AC2 adder scheduler.
package ac2_pkg;

  localparam int N_SR = 4;

  typedef logic [1:0] sr_idx_t;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} ac2_state_t;

  function automatic logic [N_SR-1:0] onehot4(input sr_idx_t idx);
    logic [N_SR-1:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ac2_sched_chk.sv
// Invariant checks for the AC2 scheduler's bookkeeping and one-hot outputs.
module ac2_sched_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [3:0] pend_set,
  input logic [3:0] pend_clr,
  input logic [3:0] gnt,
  input logic [3:0] wb_en
);

  a_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
    (pend_set & pend_clr) == 4'b0000);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));

  a_wb_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(wb_en));

endmodule

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter: first set request at or after ptr.
module rr_arb4
  import ac2_pkg::*;
(
  input  logic [3:0] req,
  input  sr_idx_t    ptr,
  output logic       valid,
  output sr_idx_t    idx
);

  sr_idx_t cand;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + sr_idx_t'(k);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/ac2_sched.sv
// Round-robin scheduler sharing the AC2 adder among four accumulation shift
// registers, with a latency-matched write-back enable.
module ac2_sched
  import ac2_pkg::*;
#(
  parameter int ADD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [N_SR-1:0] req,
  output logic [N_SR-1:0] gnt,
  output sr_idx_t       sel_w_en,
  output logic          add_valid,
  input  logic          add_ready,
  output logic [N_SR-1:0] wb_en,
  output sr_idx_t       wb_sel,
  output logic          busy
);

  ac2_state_t      state, state_n;
  logic [N_SR-1:0] pending, gnt_q, elig, pend_set;
  sr_idx_t         rr_ptr, win_idx;
  logic            win_valid, fire, load;
  logic [ADD_LAT-1:0] dl_v;
  sr_idx_t         dl_idx [ADD_LAT];

  // gnt_q masks a requester still holding req in the cycle after its grant
  assign elig      = req & ~pending & ~gnt_q;
  assign add_valid = (state == ISSUE);
  assign fire      = add_valid & add_ready;
  assign gnt       = (fire && !clear) ? onehot4(sel_w_en) : 4'b0000;
  assign wb_en     = dl_v[ADD_LAT-1] ? onehot4(dl_idx[ADD_LAT-1]) : 4'b0000;
  assign wb_sel    = dl_v[ADD_LAT-1] ? dl_idx[ADD_LAT-1] : 2'd0;
  assign busy      = add_valid | (|pending);
  assign pend_set  = load ? onehot4(win_idx) : 4'b0000;

  rr_arb4 u_arb (
    .req   (elig),
    .ptr   (rr_ptr),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          load    = 1'b1;
          state_n = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        if (fire && win_valid) begin
          load    = 1'b1;
          state_n = ISSUE;
        end else if (fire) begin
          state_n = IDLE;
        end else begin
          state_n = ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // clear flushes in-flight work but keeps rr_ptr and sel_w_en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_w_en <= 2'd0;
      pending  <= 4'b0000;
      rr_ptr   <= 2'd0;
      gnt_q    <= 4'b0000;
      dl_v     <= '0;
      for (int i = 0; i < ADD_LAT; i++) dl_idx[i] <= 2'd0;
    end else if (clear) begin
      state   <= IDLE;
      pending <= 4'b0000;
      gnt_q   <= 4'b0000;
      dl_v    <= '0;
    end else begin
      state   <= state_n;
      gnt_q   <= gnt;
      pending <= (pending & ~wb_en) | pend_set;
      if (load) begin
        sel_w_en <= win_idx;
        rr_ptr   <= win_idx + 2'd1;
      end
      dl_v[0]   <= fire;
      dl_idx[0] <= sel_w_en;
      for (int i = 1; i < ADD_LAT; i++) begin
        dl_v[i]   <= dl_v[i-1];
        dl_idx[i] <= dl_idx[i-1];
      end
    end
  end

  ac2_sched_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .pend_set (pend_set),
    .pend_clr (wb_en),
    .gnt      (gnt),
    .wb_en    (wb_en)
  );

endmodule

// File: doc/ac2_sched.md
Name: ac2_sched

Overview:
- Scheduler that shares the single AC2 adder among the four accumulation shift registers.
- Arbitrates their requests round-robin and drives the AC2 mux select (sel_w_en) and the adder valid/ready handshake.
- After the adder latency, issues a one-hot write-back enable so the sum returns to the shift register it came from.
- Sits between the shift-register bank, ac2_mux and the AC2 adder in the SMAC accumulation path.

Parameters:
- ADD_LAT, 1: adder latency in cycles from accepted operand to result valid. Legal range 1..8.
- N_SR, 4: number of shift registers. Fixed at 4; taken from the package and not overridable.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- clear  in  1  synchronous flush of in-flight work; lower priority than rst_n.
- req  in  4  req[i]=1: shift register i holds an operand for the adder. Held until its gnt[i].
- gnt  out  4  one-hot acknowledge to the requester, asserted in the transfer cycle.
- sel_w_en  out  2  select to ac2_mux; index of the granted shift register.
- add_valid  out  1  operand presented to the adder.
- add_ready  in  1  adder accepts the operand this cycle.
- wb_en  out  4  one-hot write-back enable, asserted the cycle the adder result is valid.
- wb_sel  out  2  index of the current write-back target.
- busy  out  1  add_valid | (|pending).

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, add_valid=0, sel_w_en=0, gnt=0, wb_en=0, wb_sel=0, pending=0, rr_ptr=0, delay line cleared, busy=0.
- Eligibility: elig = req & ~pending & ~gnt_q. gnt_q is gnt registered one cycle, which masks a requester that has not yet dropped req.
- Priority: round-robin starting at rr_ptr, order rr_ptr, rr_ptr+1, ... mod 4. rr_ptr is reset to 0.
- IDLE, with |elig=1: at the edge, register the winner w. sel_w_en<=w, add_valid<=1, pending[w]<=1, rr_ptr<=w+1 mod 4, go to ISSUE.
- ISSUE: sel_w_en and add_valid are held stable while add_ready=0.
- Transfer (fire): add_valid & add_ready.
  - gnt = onehot(sel_w_en), combinational from registered state, gated by fire.
  - Launch {1, sel_w_en} into the ADD_LAT-deep delay line.
  - If |elig in the same cycle: load the next winner and stay in ISSUE (back-to-back, one issue per cycle).
  - Otherwise: add_valid<=0, go to IDLE.
- Throughput: one issue per cycle is sustainable when different registers request.
- Latency:
  - req rising to add_valid: 1 cycle when idle.
  - fire to wb_en: exactly ADD_LAT cycles.
- Write-back: when the delay-line tail is valid, wb_en=onehot(idx), wb_sel=idx, and pending[idx] is cleared at that edge.
- Single-operation rule: one shift register is never issued again before its write-back. It becomes eligible again in the cycle after wb_en.
- Set/clear collision: pending set and clear cannot hit the same index in the same cycle by construction. An assertion checks this.
- clear=1:
  - Next cycle: add_valid=0, gnt=0, pending=0, delay line flushed, state=IDLE.
  - No wb_en is issued for flushed operations.
  - rr_ptr is kept.
- rst_n mid-operation: same outputs as reset; in-flight results are discarded.
- Simultaneous clear and fire: clear wins. No gnt is issued that cycle.
- All-four request, contention-free: grant order 0,1,2,3, then back to 0 only after its write-back.
- Invariants:
  - gnt and wb_en are each one-hot or zero.
  - sel_w_en is stable while add_valid & ~add_ready.

Decomposition:
- Package ac2_pkg:
  - localparam N_SR=4
  - typedef logic [1:0] sr_idx_t
  - typedef enum logic {IDLE, ISSUE} ac2_state_t
  - function onehot4(sr_idx_t)
- Sub-module rr_arb4: combinational round-robin, 4-bit request and 2-bit pointer in, grant valid and index out. Reused by other shared-resource schedulers.
- Delay line: inline shift array of {valid, sr_idx_t}, depth ADD_LAT.

Test Plan:
1. Reset, then req=4'b0001 with add_ready=1, ADD_LAT=1 → add_valid at cycle 1 with sel_w_en=0; gnt=0001 at cycle 1; wb_en=0001 and wb_sel=0 at cycle 2; busy low at cycle 3.
2. req=4'b1111 held, add_ready=1, ADD_LAT=3 → sel_w_en sequence 0,1,2,3 on consecutive cycles; register 0 is not re-granted before its wb_en; wb_en order 0001, 0010, 0100, 1000.
3. req=4'b0110, add_ready=0 for 5 cycles, then 1 → sel_w_en=1 held and add_valid high for all 5 stall cycles; gnt=0010 only on the ready cycle; register 2 issued next cycle.
4. Two requests in flight with ADD_LAT=4, then clear pulse → next cycle add_valid=0 and pending=0; no wb_en for the 4 following cycles; a new req=4'b1000 issues normally with rr_ptr retained.
5. rst_n=0 asserted while in ISSUE with add_valid=1 → next edge: all outputs 0 and state=IDLE; after release, req=4'b0100 is granted with sel_w_en=2.
6. Simultaneous clear=1 and add_ready=1 while add_valid=1 → gnt=0 that cycle, no delay-line launch, no later wb_en.
